// File: rtl/alu_nibble_seq_if.sv
// Bus between the instruction decoder, the nibble sequencer and the external alu4 slice.
// The slave modport is the sequencer's view; master is the decoder/alu4 side.
interface alu_nibble_seq_if;
  logic       START;
  logic [7:0] OPA;
  logic [7:0] OPB;
  logic       CIN;
  logic       MODE;
  logic [3:0] SEL;
  logic [3:0] ALU_A;
  logic [3:0] ALU_B;
  logic       ALU_CI;
  logic       ALU_M;
  logic [3:0] ALU_S;
  logic [3:0] ALU_F;
  logic       ALU_CO;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RES;
  logic       COUT;
  logic       ZF;
  logic       NF;
  logic       VF;

  modport slave (
    input  START, OPA, OPB, CIN, MODE, SEL, ALU_F, ALU_CO,
    output ALU_A, ALU_B, ALU_CI, ALU_M, ALU_S,
    output BUSY, DONE, RES, COUT, ZF, NF, VF
  );

  modport master (
    output START, OPA, OPB, CIN, MODE, SEL, ALU_F, ALU_CO,
    input  ALU_A, ALU_B, ALU_CI, ALU_M, ALU_S,
    input  BUSY, DONE, RES, COUT, ZF, NF, VF
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// Runs an 8-bit op through one external 4-bit ALU slice as low nibble then high
// nibble, chaining the carry through a register, and gathers RES/C/Z/N/V.
module alu_nibble_seq #(
  parameter logic [3:0] S_ADD = 4'b1001,
  parameter logic [3:0] S_SUB = 4'b0110
) (
  input  logic             CLK,
  input  logic             RST,
  alu_nibble_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic [7:0] opa_q, opb_q;
  logic       cin_q, mode_q;
  logic [3:0] sel_q;
  logic [3:0] lo_f_q;
  logic       cy_q;
  logic [7:0] res_q;
  logic       cout_q, zf_q, nf_q, vf_q;

  logic [3:0] alu_a, alu_b;
  logic       alu_ci, busy, done;
  logic       v_en, b7;

  // Overflow only has meaning for the add/subtract selects in arithmetic mode;
  // subtract feeds the inverted B sign into the same same-sign test.
  assign v_en = mode_q && ((sel_q == S_ADD) || (sel_q == S_SUB));
  assign b7   = (sel_q == S_SUB) ? ~opb_q[7] : opb_q[7];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ci    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.START) begin
          accept    = 1'b1;
          state_nxt = LO;
        end
      end
      LO: begin
        busy      = 1'b1;
        alu_a     = opa_q[3:0];
        alu_b     = opb_q[3:0];
        alu_ci    = cin_q;
        state_nxt = HI;
      end
      HI: begin
        busy      = 1'b1;
        alu_a     = opa_q[7:4];
        alu_b     = opb_q[7:4];
        alu_ci    = cy_q;
        state_nxt = FIN;
      end
      FIN: begin
        done = 1'b1;
        if (bus.START) begin
          accept    = 1'b1;
          state_nxt = LO;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      opa_q  <= '0;
      opb_q  <= '0;
      cin_q  <= 1'b0;
      mode_q <= 1'b0;
      sel_q  <= '0;
      lo_f_q <= '0;
      cy_q   <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
      zf_q   <= 1'b0;
      nf_q   <= 1'b0;
      vf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opa_q  <= bus.OPA;
        opb_q  <= bus.OPB;
        cin_q  <= bus.CIN;
        mode_q <= bus.MODE;
        sel_q  <= bus.SEL;
      end
      if (state == LO) begin
        lo_f_q <= bus.ALU_F;
        cy_q   <= bus.ALU_CO;
      end
      if (state == HI) begin
        res_q  <= {bus.ALU_F, lo_f_q};
        cout_q <= mode_q ? bus.ALU_CO : cin_q;
        zf_q   <= ({bus.ALU_F, lo_f_q} == 8'h00);
        nf_q   <= bus.ALU_F[3];
        vf_q   <= v_en && (opa_q[7] == b7) && (bus.ALU_F[3] != opa_q[7]);
      end
    end
  end

  assign bus.ALU_A  = alu_a;
  assign bus.ALU_B  = alu_b;
  assign bus.ALU_CI = alu_ci;
  assign bus.ALU_M  = mode_q;
  assign bus.ALU_S  = sel_q;
  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.RES    = res_q;
  assign bus.COUT   = cout_q;
  assign bus.ZF     = zf_q;
  assign bus.NF     = nf_q;
  assign bus.VF     = vf_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Scoreboard bench for alu_nibble_seq: models alu4 on the bus, predicts 8-bit
// results with whole-byte arithmetic and checks every DONE and every ALU drive.
module tb_alu_nibble_seq;

  localparam logic [3:0] ADD = 4'b1001;
  localparam logic [3:0] SUB = 4'b0110;

  logic clk;
  logic rst;
  alu_nibble_seq_if bus();

  alu_nibble_seq #(.S_ADD(ADD), .S_SUB(SUB)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // alu4 slice model: M=1 arithmetic, M=0 logic; CO only meaningful in arithmetic.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    if (bus.ALU_M) begin
      case (bus.ALU_S)
        ADD:     alu_sum = {1'b0, bus.ALU_A} + {1'b0, bus.ALU_B} + {4'b0, bus.ALU_CI};
        SUB:     alu_sum = {1'b0, bus.ALU_A} + {1'b0, ~bus.ALU_B} + {4'b0, bus.ALU_CI};
        default: alu_sum = {1'b0, bus.ALU_A} + {4'b0, bus.ALU_CI};
      endcase
    end else begin
      case (bus.ALU_S)
        4'b0110: alu_sum = {1'b0, bus.ALU_A ^ bus.ALU_B};
        4'b1011: alu_sum = {1'b0, bus.ALU_A & bus.ALU_B};
        4'b1110: alu_sum = {1'b0, bus.ALU_A | bus.ALU_B};
        default: alu_sum = {1'b0, bus.ALU_A};
      endcase
    end
    bus.ALU_F  = alu_sum[3:0];
    bus.ALU_CO = alu_sum[4];
  end

  typedef struct {
    logic [7:0] opa, opb;
    logic       cin;
    logic [7:0] res;
    logic       c, z, n, v, hi_ci;
    int         acc;
  } exp_t;

  // directed table: {opa, opb, cin, mode, sel, res, c, z, n, v}
  logic [33:0] dir_tab [5];
  int          dir_idx;
  int          checks, failures;
  int          edge_cnt;
  int          ph;
  logic        lat_mode;
  logic [3:0]  lat_sel;
  exp_t        q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t make_exp(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                    input logic mode, input logic [3:0] sel, input int didx,
                                    input int acc);
    exp_t e;
    int bb, sum, sa, sb, ss;
    logic [33:0] d;
    e.opa = a; e.opb = b; e.cin = cin; e.acc = acc;
    e.v = 1'b0; e.hi_ci = 1'b0; e.c = cin;
    if (mode && (sel == ADD || sel == SUB)) begin
      bb  = (sel == SUB) ? 255 - int'(b) : int'(b);
      sum = int'(a) + bb + int'(cin);
      e.res = sum[7:0];
      e.c   = (sum > 255);
      sa = (int'(a) >= 128) ? int'(a) - 256 : int'(a);
      sb = (bb >= 128) ? bb - 256 : bb;
      ss = sa + sb + int'(cin);
      e.v = (ss > 127) || (ss < -128);
      e.hi_ci = ((int'(a) % 16) + (bb % 16) + int'(cin)) >= 16;
    end else if (mode) begin
      sum = int'(a) + int'(cin);
      e.res = sum[7:0];
      e.c   = (sum > 255);
      e.hi_ci = ((int'(a) % 16) + int'(cin)) >= 16;
    end else begin
      case (sel)
        4'b0110: e.res = a ^ b;
        4'b1011: e.res = a & b;
        4'b1110: e.res = a | b;
        default: e.res = a;
      endcase
    end
    e.z = (e.res == 8'h00);
    e.n = e.res[7];
    if (didx >= 0) begin
      d = dir_tab[didx];
      e.res = d[11:4];
      e.c = d[3]; e.z = d[2]; e.n = d[1]; e.v = d[0];
    end
    return e;
  endfunction

  // Reference sequencing: accept from idle or finish, two busy cycles, one done cycle.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (rst) begin
      if ((ph == 1 || ph == 2) && q.size() > 0) q.delete(q.size() - 1);
      ph       <= 0;
      lat_mode <= 1'b0;
      lat_sel  <= '0;
    end else begin
      case (ph)
        1: ph <= 2;
        2: ph <= 3;
        default: begin
          if (bus.START) begin
            q.push_back(make_exp(bus.OPA, bus.OPB, bus.CIN, bus.MODE, bus.SEL, dir_idx, edge_cnt + 1));
            lat_mode <= bus.MODE;
            lat_sel  <= bus.SEL;
            ph       <= 1;
          end else begin
            ph <= 0;
          end
        end
      endcase
    end
  end

  // Monitor: checks drive nibbles every cycle and pops the scoreboard on DONE.
  always @(negedge clk) begin
    exp_t e;
    if (ph != 0 || bus.DONE || bus.BUSY) begin
      check("busy", {31'b0, bus.BUSY}, {31'b0, (ph == 1 || ph == 2)});
      check("done", {31'b0, bus.DONE}, {31'b0, (ph == 3)});
      check("alu_ms", {27'b0, bus.ALU_M, bus.ALU_S}, {27'b0, lat_mode, lat_sel});
      if (ph == 1 && q.size() > 0) begin
        e = q[q.size() - 1];
        check("lo_drive", {23'b0, bus.ALU_A, bus.ALU_B, bus.ALU_CI},
              {23'b0, e.opa[3:0], e.opb[3:0], e.cin});
      end else if (ph == 2 && q.size() > 0) begin
        e = q[q.size() - 1];
        check("hi_drive", {23'b0, bus.ALU_A, bus.ALU_B, bus.ALU_CI},
              {23'b0, e.opa[7:4], e.opb[7:4], e.hi_ci});
      end else begin
        check("idle_drive", {23'b0, bus.ALU_A, bus.ALU_B, bus.ALU_CI}, 32'h0);
      end
      if (bus.DONE) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = q.pop_front();
          check("latency", edge_cnt, e.acc + 2);
          check("result", {20'b0, bus.RES, bus.COUT, bus.ZF, bus.NF, bus.VF},
                {20'b0, e.res, e.c, e.z, e.n, e.v});
        end
      end
    end
  end

  task automatic drive_rand();
    bus.OPA  = 8'($urandom);
    bus.OPB  = 8'($urandom);
    bus.CIN  = 1'($urandom);
    bus.MODE = 1'($urandom);
    bus.SEL  = 4'($urandom);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic mode, input logic [3:0] sel, input int didx);
    bus.OPA = a; bus.OPB = b; bus.CIN = cin; bus.MODE = mode; bus.SEL = sel;
    dir_idx = didx;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    dir_idx = -1;
    drive_rand();
    repeat (3) @(negedge clk);
  endtask

  task automatic issue_dir(input int i);
    logic [33:0] d;
    d = dir_tab[i];
    issue(d[33:26], d[25:18], d[17], d[16], d[15:12], i);
  endtask

  task automatic check_cleared(input string name);
    check(name, {16'b0, bus.BUSY, bus.DONE, bus.RES, bus.COUT, bus.ZF, bus.NF, bus.VF}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic m;
    checks = 0; failures = 0; edge_cnt = 0; ph = 0; dir_idx = -1;
    lat_mode = 1'b0; lat_sel = '0;
    dir_tab[0] = {8'h3A, 8'h47, 1'b0, 1'b1, ADD,     8'h81, 4'b0011};
    dir_tab[1] = {8'hFF, 8'h01, 1'b0, 1'b1, ADD,     8'h00, 4'b1100};
    dir_tab[2] = {8'h50, 8'h10, 1'b1, 1'b1, SUB,     8'h40, 4'b1000};
    dir_tab[3] = {8'h80, 8'h01, 1'b1, 1'b1, SUB,     8'h7F, 4'b1001};
    dir_tab[4] = {8'hF0, 8'h3C, 1'b1, 1'b0, 4'b0110, 8'hCC, 4'b1010};
    rst = 1'b1;
    bus.START = 1'b0;
    drive_rand();
    repeat (3) @(negedge clk);
    check_cleared("reset_outputs");
    check("reset_drive", {19'b0, bus.ALU_A, bus.ALU_B, bus.ALU_CI, bus.ALU_M, bus.ALU_S}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) issue_dir(i);

    // START held high with inputs churning: accepts only at idle/finish edges
    bus.START = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rand();
      @(negedge clk);
    end
    bus.START = 1'b0;
    repeat (4) @(negedge clk);

    // START re-asserted during LO and HI is ignored
    bus.OPA = 8'h21; bus.OPB = 8'h13; bus.CIN = 1'b0; bus.MODE = 1'b1; bus.SEL = ADD;
    bus.START = 1'b1;
    @(negedge clk);
    drive_rand();
    @(negedge clk);
    drive_rand();
    @(negedge clk);
    bus.START = 1'b0;
    repeat (3) @(negedge clk);

    // reset in HI aborts the op
    bus.OPA = 8'h12; bus.OPB = 8'h34; bus.CIN = 1'b0; bus.MODE = 1'b1; bus.SEL = ADD;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("reset_abort");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    issue_dir(0);

    for (int i = 0; i < 60; i++) begin
      m = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       issue(8'($urandom), 8'($urandom), 1'($urandom), m, m ? ADD : 4'b0110, -1);
        1:       issue(8'($urandom), 8'($urandom), 1'($urandom), m, m ? SUB : 4'b1011, -1);
        default: issue(8'($urandom), 8'($urandom), 1'($urandom), m, m ? ADD : 4'b1110, -1);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
